receptor_pedido_serial: RTL and testbench
=========================================

// Module: receptor_pedido_serial
// PURPOSE
//  UART 8N1 receiver and request parser that feeds the smart_cargo
//  datapath with transport requests (origin floor, destination floor).
//  It sits between the RX pin and the new-destination entry logic:
//  - synchronises RX and deserialises bytes;
//  - validates each byte as a request;
//  - holds one pending request until the consumer accepts it.
// PARAMETERS
//  CICLOS_POR_BIT  5208  clock cycles per UART bit (50 MHz / 9600 baud); must be >= 4
//  CABECALHO       4'hA  required value of byte bits [7:4]
// PORTS
//  clock           in   1  system clock, rising edge
//  reset           in   1  asynchronous, active-high; returns block to idle
//  RX              in   1  UART line, idle high, asynchronous to clock
//  pedido_aceito   in   1  consumer takes the pending request (1-cycle pulse)
//  limpa_erros     in   1  clears the sticky error flags
//  origem          out  2  origin floor of the pending request
//  destino         out  2  destination floor of the pending request
//  pedido_pronto   out  1  a valid request is pending (level)
//  erro_quadro     out  1  sticky: stop bit sampled low
//  erro_pedido     out  1  sticky: bad header, or origem == destino
//  overflow        out  1  sticky: valid request dropped because the slot was full
//  db_byte         out  8  last byte received (valid or not)
//  db_estado       out  3  current FSM state code
// BEHAVIOUR
//  Reset values:
//  - all outputs 0;
//  - RX synchroniser flops preset to 1;
//  - FSM in OCIOSO.
//  Input path: RX passes through 2 flip-flops (rx_s); edge detection uses rx_s only.
//  FSM (db_estado codes):
//  - OCIOSO=0: on rx_s 1->0, clear the counter and go to INICIO.
//  - INICIO=1: at count CICLOS_POR_BIT/2-1, sample rx_s.
//    - 1 -> glitch: back to OCIOSO, nothing reported.
//    - 0 -> go to DADOS.
//  - DADOS=2: every CICLOS_POR_BIT cycles, sample one bit, LSB first, into the shift register.
//    After bit 7, go to PARADA.
//  - PARADA=3: CICLOS_POR_BIT cycles after the bit-7 sample, sample the stop bit.
//    Then go to VALIDA.
//  - VALIDA=4: one cycle. db_byte <= byte, then:
//    - stop bit = 0: erro_quadro <= 1; request discarded.
//    - byte[7:4] != CABECALHO, or byte[1:0] == byte[3:2]: erro_pedido <= 1; discarded.
//    - otherwise the request is valid; see the slot rules below.
//    Always return to OCIOSO the next cycle.
//  Byte format: [7:4] = header, [3:2] = destino, [1:0] = origem.
//  Latency: pedido_pronto rises on the clock edge that ends VALIDA,
//  i.e. 2 cycles after the stop-bit sample.
//  Slot rules (one-entry buffer) for a valid request:
//  - pedido_pronto = 0: load origem/destino; pedido_pronto <= 1.
//  - pedido_pronto = 1 and no pedido_aceito: request dropped; overflow <= 1;
//    origem/destino unchanged.
//  - pedido_pronto = 1 and pedido_aceito in the same cycle: load the new request;
//    pedido_pronto stays 1; no overflow.
//  pedido_aceito while pedido_pronto = 1 and not in VALIDA: pedido_pronto <= 0 next cycle.
//  origem/destino keep their last value after acceptance.
//  pedido_aceito while pedido_pronto = 0: ignored.
//  Sticky flags:
//  - set as above;
//  - limpa_erros clears all three next cycle;
//  - a flag set in the same cycle as limpa_erros wins (flag = 1).
//  Counter: wide enough for CICLOS_POR_BIT-1. It is cleared on every sample point,
//  so there is no wrap-around inside a frame.
//  Reset asserted mid-frame: frame aborted, no flag set, pending request lost.
//  After release, the block waits for a fresh falling edge.
//  A line held low (break): frame ends with erro_quadro.
//  The FSM then waits in OCIOSO for rx_s to return high before a new start.
// TESTING  (CICLOS_POR_BIT = 16)
//  1. Send 0xA6 -> destino=2'b01, origem=2'b10, pedido_pronto=1 two cycles after
//     the stop sample; no flags set; db_byte=0xA6.
//  2. Send 0xA5 (origem == destino), then 0x56 (bad header) -> erro_pedido=1,
//     pedido_pronto=0, db_byte=0x56; pulse limpa_erros -> erro_pedido=0.
//  3. Send 0xA6 then 0xA9 with no ack -> origem=2'b10, destino=2'b01 kept, overflow=1.
//     Repeat with pedido_aceito pulsed in VALIDA of 0xA9 -> origem=2'b01,
//     destino=2'b10, pedido_pronto=1, overflow=0.
//  4. Frame 0xA6 with the stop bit driven 0 -> erro_quadro=1, pedido_pronto=0,
//     db_byte=0xA6.
//  5. RX low for 5 cycles then high (glitch) -> FSM returns to OCIOSO,
//     no outputs change.
//  6. Assert reset during bit 4 of a frame, release it, send 0xA6 ->
//     clean reception as in test 1.

Source files
------------

// File: rtl/receptor_pedido_serial.sv
// UART 8N1 receiver and request parser: deserialises bytes from RX, validates them as
// (origem, destino) transport requests and holds one pending request for the consumer.
module receptor_pedido_serial #(
    parameter int         CICLOS_POR_BIT = 5208,
    parameter logic [3:0] CABECALHO      = 4'hA
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RX,
    input  logic       pedido_aceito,
    input  logic       limpa_erros,
    output logic [1:0] origem,
    output logic [1:0] destino,
    output logic       pedido_pronto,
    output logic       erro_quadro,
    output logic       erro_pedido,
    output logic       overflow,
    output logic [7:0] db_byte,
    output logic [2:0] db_estado
);

    localparam int CW = $clog2(CICLOS_POR_BIT);
    localparam logic [CW-1:0] MEIO = CW'(CICLOS_POR_BIT / 2 - 1);
    localparam logic [CW-1:0] FIM  = CW'(CICLOS_POR_BIT - 1);

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        INICIO = 3'd1,
        DADOS  = 3'd2,
        PARADA = 3'd3,
        VALIDA = 3'd4
    } estado_t;

    estado_t       estado;
    estado_t       prox;
    logic          rx_m;
    logic          rx_s;
    logic          rx_ant;
    logic [CW-1:0] cont;
    logic [2:0]    n_bit;
    logic [7:0]    desloc;
    logic          bit_parada;
    logic          limpa_cont;
    logic          amostra;

    logic em_valida;
    logic falha_quadro;
    logic falha_pedido;
    logic valido;
    logic seta_quadro;
    logic seta_pedido;
    logic seta_overflow;
    logic carrega;

    // RX is asynchronous: two-flop synchroniser, plus one more flop of rx_s for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            rx_ant <= 1'b1;
        end else begin
            rx_m   <= RX;
            rx_s   <= rx_m;
            rx_ant <= rx_s;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= prox;
    end

    always_comb begin
        prox       = estado;
        limpa_cont = 1'b0;
        amostra    = 1'b0;
        case (estado)
            OCIOSO: begin
                // A held-low line never produces a new edge until it returns high
                if (rx_ant && !rx_s) begin
                    prox       = INICIO;
                    limpa_cont = 1'b1;
                end
            end
            INICIO: begin
                if (cont == MEIO) begin
                    limpa_cont = 1'b1;
                    prox       = rx_s ? OCIOSO : DADOS;
                end
            end
            DADOS: begin
                if (cont == FIM) begin
                    limpa_cont = 1'b1;
                    amostra    = 1'b1;
                    if (n_bit == 3'd7) prox = PARADA;
                end
            end
            PARADA: begin
                if (cont == FIM) begin
                    limpa_cont = 1'b1;
                    amostra    = 1'b1;
                    prox       = VALIDA;
                end
            end
            VALIDA:  prox = OCIOSO;
            default: prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cont  <= '0;
            n_bit <= 3'd0;
        end else begin
            cont <= limpa_cont ? '0 : cont + 1'b1;
            if (estado == INICIO)
                n_bit <= 3'd0;
            else if (amostra && estado == DADOS)
                n_bit <= n_bit + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (amostra && estado == DADOS)  desloc     <= {rx_s, desloc[7:1]};
        if (amostra && estado == PARADA) bit_parada <= rx_s;
    end

    assign em_valida     = (estado == VALIDA);
    assign falha_quadro  = !bit_parada;
    assign falha_pedido  = (desloc[7:4] != CABECALHO) || (desloc[1:0] == desloc[3:2]);
    assign valido        = em_valida && !falha_quadro && !falha_pedido;
    assign seta_quadro   = em_valida && falha_quadro;
    assign seta_pedido   = em_valida && !falha_quadro && falha_pedido;
    assign seta_overflow = valido && pedido_pronto && !pedido_aceito;
    assign carrega       = valido && (!pedido_pronto || pedido_aceito);

    // A flag raised in the same cycle as limpa_erros stays set
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            erro_quadro <= 1'b0;
            erro_pedido <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            erro_quadro <= seta_quadro   || (erro_quadro && !limpa_erros);
            erro_pedido <= seta_pedido   || (erro_pedido && !limpa_erros);
            overflow    <= seta_overflow || (overflow    && !limpa_erros);
        end
    end

    // One-entry slot: a request accepted in the same cycle frees room for the new one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            origem        <= 2'b00;
            destino       <= 2'b00;
            pedido_pronto <= 1'b0;
            db_byte       <= 8'h00;
        end else begin
            if (em_valida) db_byte <= desloc;
            if (carrega) begin
                origem        <= desloc[1:0];
                destino       <= desloc[3:2];
                pedido_pronto <= 1'b1;
            end else if (pedido_aceito && pedido_pronto) begin
                pedido_pronto <= 1'b0;
            end
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_receptor_pedido_serial.sv
// Bench for receptor_pedido_serial: directed frames plus random frames against a
// request-level reference model of the slot and sticky flags.
module tb_receptor_pedido_serial;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       RX = 1'b1;
    logic       pedido_aceito = 1'b0;
    logic       limpa_erros = 1'b0;
    logic [1:0] origem;
    logic [1:0] destino;
    logic       pedido_pronto;
    logic       erro_quadro;
    logic       erro_pedido;
    logic       overflow;
    logic [7:0] db_byte;
    logic [2:0] db_estado;

    int comparados  = 0;
    int divergentes = 0;

    // reference model state
    logic [1:0] m_origem, m_destino;
    logic       m_pronto, m_eq, m_ep, m_ov;
    logic [7:0] m_byte;

    // current frame context
    logic [7:0] cur_byte;
    logic       cur_stop, cur_ack, cur_clr;
    int         valida_vista;
    logic       checa_proximo = 1'b0;

    receptor_pedido_serial #(.CICLOS_POR_BIT(CPB), .CABECALHO(4'hA)) dut (
        .clock(clock), .reset(reset), .RX(RX),
        .pedido_aceito(pedido_aceito), .limpa_erros(limpa_erros),
        .origem(origem), .destino(destino), .pedido_pronto(pedido_pronto),
        .erro_quadro(erro_quadro), .erro_pedido(erro_pedido), .overflow(overflow),
        .db_byte(db_byte), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        comparados++;
        if (obs !== exp) begin
            divergentes++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic confere_tudo(input string tag);
        confere({tag, "_origem"},  origem,        m_origem);
        confere({tag, "_destino"}, destino,       m_destino);
        confere({tag, "_pronto"},  pedido_pronto, m_pronto);
        confere({tag, "_quadro"},  erro_quadro,   m_eq);
        confere({tag, "_pedido"},  erro_pedido,   m_ep);
        confere({tag, "_ovf"},     overflow,      m_ov);
        confere({tag, "_byte"},    db_byte,       m_byte);
        confere({tag, "_estado"},  db_estado,     3'd0);
    endtask

    task automatic modelo_reset();
        m_origem = 2'b00; m_destino = 2'b00; m_pronto = 1'b0;
        m_eq = 1'b0; m_ep = 1'b0; m_ov = 1'b0; m_byte = 8'h00;
    endtask

    function automatic bit pedido_ruim(input logic [7:0] b);
        return (b[7:4] != 4'hA) || (b[1:0] == b[3:2]);
    endfunction

    // Request-level outcome of a completed frame
    task automatic modelo_valida();
        m_byte = cur_byte;
        if (cur_clr) begin
            m_eq = 1'b0; m_ep = 1'b0; m_ov = 1'b0;
        end
        if (!cur_stop)
            m_eq = 1'b1;
        else if (pedido_ruim(cur_byte))
            m_ep = 1'b1;
        else if (!m_pronto || cur_ack) begin
            m_origem  = cur_byte[1:0];
            m_destino = cur_byte[3:2];
            m_pronto  = 1'b1;
        end else
            m_ov = 1'b1;
    endtask

    task automatic ciclo();
        @(posedge clock);
        #1;
        pedido_aceito = 1'b0;
        limpa_erros   = 1'b0;
        if (checa_proximo) begin
            checa_proximo = 1'b0;
            confere_tudo("apos_valida");
        end
        if (db_estado == 3'd4) begin
            valida_vista++;
            confere("pronto_em_valida", pedido_pronto, m_pronto);
            if (cur_ack) pedido_aceito = 1'b1;
            if (cur_clr) limpa_erros = 1'b1;
            modelo_valida();
            checa_proximo = 1'b1;
        end
    endtask

    task automatic ocioso(input int n, input bit ack, input bit clr);
        pedido_aceito = ack;
        limpa_erros   = clr;
        if (ack && m_pronto) m_pronto = 1'b0;
        if (clr) begin
            m_eq = 1'b0; m_ep = 1'b0; m_ov = 1'b0;
        end
        for (int i = 0; i < n; i++) ciclo();
    endtask

    task automatic envia(input logic [7:0] b, input bit stop_ok, input bit ack, input bit clr);
        logic [9:0] quadro;
        quadro       = {stop_ok, b, 1'b0};
        cur_byte     = b;
        cur_stop     = stop_ok;
        cur_ack      = ack;
        cur_clr      = clr;
        valida_vista = 0;
        for (int i = 0; i < 10; i++) begin
            RX = quadro[i];
            for (int k = 0; k < CPB; k++) ciclo();
        end
        RX = 1'b1;
        ciclo();
        ciclo();
        confere("valida_vista", valida_vista, 1);
    endtask

    initial begin
        logic [7:0] b;
        bit         st, ak, cl;
        int         viu_inicio;
        logic [9:0] quadro;

        modelo_reset();
        repeat (3) @(posedge clock);
        #1;
        confere_tudo("reset");
        reset = 1'b0;
        ocioso(4, 1'b0, 1'b0);

        // 1: clean request
        envia(8'hA6, 1'b1, 1'b0, 1'b0);
        ocioso(4, 1'b0, 1'b0);
        confere_tudo("t1");
        confere("t1_origem_lit", origem, 2'b10);
        confere("t1_destino_lit", destino, 2'b01);

        // 2: origem == destino, then bad header
        ocioso(4, 1'b1, 1'b0);
        envia(8'hA5, 1'b1, 1'b0, 1'b0);
        envia(8'h56, 1'b1, 1'b0, 1'b0);
        ocioso(4, 1'b0, 1'b0);
        confere_tudo("t2");
        confere("t2_byte_lit", db_byte, 8'h56);
        ocioso(4, 1'b0, 1'b1);
        confere("t2_limpo", erro_pedido, 1'b0);

        // 3: overflow, then accept in the same cycle as the new request
        envia(8'hA6, 1'b1, 1'b0, 1'b0);
        envia(8'hA9, 1'b1, 1'b0, 1'b0);
        ocioso(4, 1'b0, 1'b0);
        confere_tudo("t3a");
        confere("t3a_ovf_lit", overflow, 1'b1);
        ocioso(4, 1'b1, 1'b1);
        envia(8'hA6, 1'b1, 1'b0, 1'b0);
        envia(8'hA9, 1'b1, 1'b1, 1'b0);
        ocioso(4, 1'b0, 1'b0);
        confere_tudo("t3b");
        confere("t3b_origem_lit", origem, 2'b01);

        // clear in the same cycle as a new error: the error stays
        envia(8'h00, 1'b1, 1'b0, 1'b1);
        ocioso(4, 1'b0, 1'b0);
        confere_tudo("set_vence");

        // 4: framing error
        ocioso(4, 1'b1, 1'b1);
        envia(8'hA6, 1'b0, 1'b0, 1'b0);
        ocioso(4, 1'b0, 1'b0);
        confere_tudo("t4");
        confere("t4_quadro_lit", erro_quadro, 1'b1);

        // 5: glitch on RX
        viu_inicio = 0;
        RX = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ciclo();
            if (db_estado == 3'd1) viu_inicio++;
        end
        RX = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ciclo();
            if (db_estado == 3'd1) viu_inicio++;
        end
        confere("t5_viu_inicio", viu_inicio > 0, 1'b1);
        confere_tudo("t5");

        // 6: reset during bit 4 with a request pending
        ocioso(2, 1'b0, 1'b1);
        envia(8'hA6, 1'b1, 1'b0, 1'b0);
        ocioso(4, 1'b0, 1'b0);
        confere("t6_pendente", pedido_pronto, 1'b1);
        quadro = {1'b1, 8'hA9, 1'b0};
        for (int c = 0; c < CPB * 5 + CPB / 2; c++) begin
            RX = quadro[c / CPB];
            ciclo();
        end
        reset = 1'b1;
        RX    = 1'b1;
        modelo_reset();
        ciclo();
        ciclo();
        confere_tudo("t6_reset");
        reset = 1'b0;
        ocioso(6, 1'b0, 1'b0);
        envia(8'hA6, 1'b1, 1'b0, 1'b0);
        ocioso(4, 1'b0, 1'b0);
        confere_tudo("t6");

        // random frames
        for (int n = 0; n < 40; n++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 9) < 6) b[7:4] = 4'hA;
            st = ($urandom_range(0, 7) != 0);
            ak = st && !pedido_ruim(b) && ($urandom_range(0, 3) == 0);
            cl = ($urandom_range(0, 7) == 0);
            envia(b, st, ak, cl);
            ocioso(4 + $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
            confere_tudo("aleat");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, divergentes);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1);
    end

endmodule
